id_decode_stage: RTL and testbench

Registered, parametrised successor to the combinational ID control decoder. It decodes one RV32I instruction (with optional M and RV32E modes) into the EX/MEM/WB control bundles and a sign-extended immediate. Results are held in an ID/EX output register behind valid/ready handshakes, with load-use stall, flush and illegal-instruction detection. It sits between the IF/ID register and the EX stage.

---
 rtl/id_pkg.sv | 53 +++++
 rtl/id_imm_gen.sv | 29 ++
 rtl/id_decode_stage.sv | 155 +++++++++++++++
 tb/tb_id_decode_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared encodings for the ID decode stage: opcodes, ALU selectors,
// MEM bundle bit positions and the NOP control bundles.
package id_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int CTRL_EX_W  = 14;
  localparam int CTRL_MEM_W = 4;

  localparam int MEM_JUMP   = 3;
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  localparam logic [CTRL_EX_W-1:0]  NOP_CTRL_EX  = 14'd0;
  localparam logic [CTRL_MEM_W-1:0] NOP_CTRL_MEM = 4'd0;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNC   = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUSRC_REG   = 2'b00,
    ALUSRC_IMM   = 2'b01,
    ALUSRC_PC4   = 2'b10,
    ALUSRC_PCIMM = 2'b11
  } alu_src_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic logic [CTRL_EX_W-1:0] pack_ctrl_ex(input alu_op_e op, input alu_src_e src,
                                                        input logic [2:0] f3, input logic [6:0] f7);
    return {op, src, f3, f7};
  endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Immediate format select and sign extension from instr[31] to XLEN.
module id_imm_gen
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32_s;

  // Assemble the 32-bit immediate for the selected format
  always_comb begin
    imm32_s = 32'd0;
    case (fmt)
      IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32_s = {instr[31:12], 12'd0};
      IMM_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32_s = 32'd0;
    endcase
  end

  assign imm = XLEN'(signed'(imm32_s));

endmodule

// File: rtl/id_decode_stage.sv
// ID stage: decodes one RV32I/M/E instruction into EX/MEM/WB control bundles and
// holds the result in an ID/EX register with load-use stall, flush and illegal detect.
module id_decode_stage
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int EN_M   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_instr,
  input  logic [XLEN-1:0]       i_pc,
  input  logic                  i_flush,
  input  logic                  i_exMemRead,
  input  logic [REG_AW-1:0]     i_exRd,
  output logic [REG_AW-1:0]     o_rdReg1,
  output logic [REG_AW-1:0]     o_rdReg2,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CTRL_EX_W-1:0]  o_ctrlEX,
  output logic [CTRL_MEM_W-1:0] o_ctrlMEM,
  output logic [REG_AW+1:0]     o_ctrlWB,
  output logic [XLEN-1:0]       o_imm,
  output logic [XLEN-1:0]       o_pc,
  output logic                  o_illegal
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  state_e                  state_r;
  logic [CTRL_EX_W-1:0]    ctrl_ex_r;
  logic [CTRL_MEM_W-1:0]   ctrl_mem_r;
  logic [REG_AW+1:0]       ctrl_wb_r;
  logic [XLEN-1:0]         imm_r, pc_r;
  logic                    illegal_r;

  logic [6:0]              opcode_s;
  alu_op_e                 alu_op_s;
  alu_src_e                alu_src_s;
  imm_fmt_e                fmt_s;
  logic [CTRL_MEM_W-1:0]   mem_s;
  logic                    reg_write_s, mem_to_reg_s, f3_on_s, use_rs1_s, use_rs2_s, known_s;
  logic [2:0]              func3_s;
  logic [6:0]              func7_s;
  logic [REG_AW-1:0]       rs1_s, rs2_s, rd_s;
  logic                    func7_ok_s, rv32e_bad_s, illegal_s, haz_s, ready_s, accept_s;
  logic [XLEN-1:0]         imm_s;

  assign opcode_s = i_instr[6:0];

  // Per-opcode decode table
  always_comb begin
    alu_op_s     = ALUOP_ADD;
    alu_src_s    = ALUSRC_REG;
    fmt_s        = IMM_NONE;
    mem_s        = NOP_CTRL_MEM;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    f3_on_s      = 1'b0;
    use_rs1_s    = 1'b0;
    use_rs2_s    = 1'b0;
    known_s      = 1'b1;
    unique case (opcode_s)
      OPC_OP:     begin alu_op_s = ALUOP_FUNC; reg_write_s = 1'b1; f3_on_s = 1'b1;
                        use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
      OPC_OP_IMM: begin alu_op_s = ALUOP_FUNC; alu_src_s = ALUSRC_IMM; fmt_s = IMM_I;
                        reg_write_s = 1'b1; f3_on_s = 1'b1; use_rs1_s = 1'b1; end
      OPC_LOAD:   begin alu_src_s = ALUSRC_IMM; fmt_s = IMM_I; mem_s[MEM_READ] = 1'b1;
                        reg_write_s = 1'b1; mem_to_reg_s = 1'b1; f3_on_s = 1'b1; use_rs1_s = 1'b1; end
      OPC_JALR:   begin alu_src_s = ALUSRC_PC4; fmt_s = IMM_I; mem_s[MEM_JUMP] = 1'b1;
                        mem_s[MEM_BRANCH] = 1'b1; reg_write_s = 1'b1; f3_on_s = 1'b1; use_rs1_s = 1'b1; end
      OPC_STORE:  begin alu_src_s = ALUSRC_IMM; fmt_s = IMM_S; mem_s[MEM_WRITE] = 1'b1;
                        f3_on_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
      OPC_BRANCH: begin alu_op_s = ALUOP_BRANCH; fmt_s = IMM_B; mem_s[MEM_BRANCH] = 1'b1;
                        f3_on_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
      OPC_LUI:    begin alu_src_s = ALUSRC_IMM; fmt_s = IMM_U; reg_write_s = 1'b1; end
      OPC_AUIPC:  begin alu_src_s = ALUSRC_PCIMM; fmt_s = IMM_U; mem_s[MEM_JUMP] = 1'b1;
                        reg_write_s = 1'b1; end
      OPC_JAL:    begin alu_src_s = ALUSRC_PC4; fmt_s = IMM_J; mem_s[MEM_JUMP] = 1'b1;
                        reg_write_s = 1'b1; end
      default:    known_s = 1'b0;
    endcase
  end

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (i_instr[31:7]),
    .fmt   (fmt_s),
    .imm   (imm_s)
  );

  assign func3_s = f3_on_s ? i_instr[14:12] : 3'd0;
  assign func7_s = (opcode_s == OPC_OP) ? i_instr[31:25] : 7'd0;
  assign rs1_s   = i_instr[15 +: REG_AW];
  assign rs2_s   = i_instr[20 +: REG_AW];
  assign rd_s    = reg_write_s ? i_instr[7 +: REG_AW] : REG_ZERO;

  assign func7_ok_s  = (i_instr[31:25] == 7'b0000000) || (i_instr[31:25] == 7'b0100000) ||
                       ((EN_M != 0) && (i_instr[31:25] == 7'b0000001));
  // RV32E has only x0..x15, so bit 4 of any field actually used must be clear
  assign rv32e_bad_s = (REG_AW == 4) && ((use_rs1_s && i_instr[19]) || (use_rs2_s && i_instr[24]) ||
                                         (reg_write_s && i_instr[11]));
  assign illegal_s   = !known_s || ((opcode_s == OPC_OP) && !func7_ok_s) || rv32e_bad_s;

  assign o_rdReg1 = use_rs1_s ? rs1_s : REG_ZERO;
  assign o_rdReg2 = use_rs2_s ? rs2_s : REG_ZERO;

  assign haz_s    = i_valid && i_exMemRead && (i_exRd != REG_ZERO) &&
                    ((use_rs1_s && (i_exRd == rs1_s)) || (use_rs2_s && (i_exRd == rs2_s)));
  assign ready_s  = i_flush || (!haz_s && ((state_r == ST_EMPTY) || i_ready));
  assign accept_s = i_valid && ready_s && !i_flush;

  // ID/EX register and EMPTY/FULL state; a drain without accept leaves a zeroed bubble
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= ST_EMPTY;
      ctrl_ex_r  <= NOP_CTRL_EX;
      ctrl_mem_r <= NOP_CTRL_MEM;
      ctrl_wb_r  <= '0;
      imm_r      <= '0;
      pc_r       <= '0;
      illegal_r  <= 1'b0;
    end else if (accept_s) begin
      state_r    <= ST_FULL;
      ctrl_ex_r  <= illegal_s ? NOP_CTRL_EX : pack_ctrl_ex(alu_op_s, alu_src_s, func3_s, func7_s);
      ctrl_mem_r <= illegal_s ? NOP_CTRL_MEM : mem_s;
      ctrl_wb_r  <= illegal_s ? '0 : {reg_write_s, mem_to_reg_s, rd_s};
      imm_r      <= illegal_s ? '0 : imm_s;
      pc_r       <= i_pc;
      illegal_r  <= illegal_s;
    end else if (i_flush || (state_r == ST_EMPTY) || i_ready) begin
      state_r    <= ST_EMPTY;
      ctrl_ex_r  <= NOP_CTRL_EX;
      ctrl_mem_r <= NOP_CTRL_MEM;
      ctrl_wb_r  <= '0;
      imm_r      <= '0;
      pc_r       <= '0;
      illegal_r  <= 1'b0;
    end
  end

  assign o_ready   = ready_s;
  assign o_valid   = (state_r == ST_FULL);
  assign o_ctrlEX  = ctrl_ex_r;
  assign o_ctrlMEM = ctrl_mem_r;
  assign o_ctrlWB  = ctrl_wb_r;
  assign o_imm     = imm_r;
  assign o_pc      = pc_r;
  assign o_illegal = illegal_r;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed decode table, hand-written handshake
// sequences and randomized traffic against a behavioural model.
module tb_id_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, flush, ex_mem_read, ready;
  logic [31:0] instr, pc;
  logic [4:0]  ex_rd;

  logic        o_ready, o_valid, ill;
  logic [4:0]  rd1, rd2;
  logic [13:0] ctrl_ex;
  logic [3:0]  ctrl_mem;
  logic [6:0]  ctrl_wb;
  logic [31:0] imm, opc;

  logic        ready_n, valid_n, ill_n;
  logic [4:0]  rd1_n, rd2_n;
  logic [13:0] ex_n;
  logic [3:0]  mem_n;
  logic [6:0]  wb_n;
  logic [31:0] imm_n, pc_n;

  logic        ready_e, valid_e, ill_e;
  logic [3:0]  rd1_e, rd2_e;
  logic [13:0] ex_e;
  logic [3:0]  mem_e;
  logic [5:0]  wb_e;
  logic [31:0] imm_e, pc_e;

  id_decode_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready), .i_instr(instr), .i_pc(pc),
    .i_flush(flush), .i_exMemRead(ex_mem_read), .i_exRd(ex_rd), .o_rdReg1(rd1), .o_rdReg2(rd2),
    .o_valid(o_valid), .i_ready(ready), .o_ctrlEX(ctrl_ex), .o_ctrlMEM(ctrl_mem), .o_ctrlWB(ctrl_wb),
    .o_imm(imm), .o_pc(opc), .o_illegal(ill));

  id_decode_stage #(.EN_M(0)) dut_nom (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_n), .i_instr(instr), .i_pc(pc),
    .i_flush(flush), .i_exMemRead(ex_mem_read), .i_exRd(ex_rd), .o_rdReg1(rd1_n), .o_rdReg2(rd2_n),
    .o_valid(valid_n), .i_ready(ready), .o_ctrlEX(ex_n), .o_ctrlMEM(mem_n), .o_ctrlWB(wb_n),
    .o_imm(imm_n), .o_pc(pc_n), .o_illegal(ill_n));

  id_decode_stage #(.REG_AW(4)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_e), .i_instr(instr), .i_pc(pc),
    .i_flush(flush), .i_exMemRead(ex_mem_read), .i_exRd(ex_rd[3:0]), .o_rdReg1(rd1_e), .o_rdReg2(rd2_e),
    .o_valid(valid_e), .i_ready(ready), .o_ctrlEX(ex_e), .o_ctrlMEM(mem_e), .o_ctrlWB(wb_e),
    .o_imm(imm_e), .o_pc(pc_e), .o_illegal(ill_e));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [13:0] ex;
    logic [3:0]  mem;
    logic [6:0]  wb;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    logic [13:0] ex;
    logic [3:0]  mem;
    logic [6:0]  wb;
    logic [31:0] imm;
    logic        ill;
    logic        ill_nom;
    logic        ill_e;
  } vec_t;

  logic        m_valid;
  dec_t        m_q;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected decode of one instruction for XLEN=32, REG_AW=5, EN_M=1
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [1:0] aop, asrc;
    logic [3:0] mem;
    logic rw, m2r, f3on, u1, u2, known, is_op;
    int imm;
    d = '0; aop = 2'd0; asrc = 2'd0; mem = 4'd0; rw = 1'b0; m2r = 1'b0;
    f3on = 1'b0; u1 = 1'b0; u2 = 1'b0; known = 1'b1; imm = 0;
    is_op = (w[6:0] == 7'b0110011);
    case (w[6:0])
      7'b0110011: begin aop = 2'd2; rw = 1'b1; f3on = 1'b1; u1 = 1'b1; u2 = 1'b1; end
      7'b0010011: begin aop = 2'd2; asrc = 2'd1; rw = 1'b1; f3on = 1'b1; u1 = 1'b1; imm = int'($signed(w[31:20])); end
      7'b0000011: begin asrc = 2'd1; mem = 4'b0010; rw = 1'b1; m2r = 1'b1; f3on = 1'b1; u1 = 1'b1;
                        imm = int'($signed(w[31:20])); end
      7'b1100111: begin asrc = 2'd2; mem = 4'b1100; rw = 1'b1; f3on = 1'b1; u1 = 1'b1; imm = int'($signed(w[31:20])); end
      7'b0100011: begin asrc = 2'd1; mem = 4'b0001; f3on = 1'b1; u1 = 1'b1; u2 = 1'b1;
                        imm = int'($signed({w[31:25], w[11:7]})); end
      7'b1100011: begin aop = 2'd1; mem = 4'b0100; f3on = 1'b1; u1 = 1'b1; u2 = 1'b1;
                        imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
      7'b0110111: begin asrc = 2'd1; rw = 1'b1; imm = int'({w[31:12], 12'd0}); end
      7'b0010111: begin asrc = 2'd3; mem = 4'b1000; rw = 1'b1; imm = int'({w[31:12], 12'd0}); end
      7'b1101111: begin asrc = 2'd2; mem = 4'b1000; rw = 1'b1;
                        imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
      default:    known = 1'b0;
    endcase
    d.rs1 = u1 ? w[19:15] : 5'd0;
    d.rs2 = u2 ? w[24:20] : 5'd0;
    d.ill = !known || (is_op && !(w[31:25] inside {7'h00, 7'h20, 7'h01}));
    if (!d.ill) begin
      d.ex  = {aop, asrc, f3on ? w[14:12] : 3'd0, is_op ? w[31:25] : 7'd0};
      d.mem = mem;
      d.wb  = {rw, m2r, rw ? w[11:7] : 5'd0};
      d.imm = imm;
    end
    return d;
  endfunction

  // One clock: check combinational outputs, advance the model, check registers
  task automatic cycle();
    dec_t d;
    logic haz, rdy, acc;
    #1;
    d   = ref_decode(instr);
    haz = valid && ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == d.rs1) || (ex_rd == d.rs2));
    rdy = flush || (!haz && (!m_valid || ready));
    acc = valid && rdy && !flush;
    chk("ready", 64'(o_ready), 64'(rdy));
    chk("rdreg", 64'({rd1, rd2}), 64'({d.rs1, d.rs2}));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_q = '0; m_pc = 32'd0;
    end else if (acc) begin
      m_valid = 1'b1; m_q = d; m_pc = pc;
    end else if (flush || !m_valid || ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("valid", 64'(o_valid), 64'(m_valid));
    if (m_valid) begin
      chk("ctrl_ex", 64'(ctrl_ex), 64'(m_q.ex));
      chk("ctrl_mem", 64'(ctrl_mem), 64'(m_q.mem));
      chk("ctrl_wb", 64'(ctrl_wb), 64'(m_q.wb));
      chk("imm", 64'(imm), 64'(m_q.imm));
      chk("pc", 64'(opc), 64'(m_pc));
      chk("illegal", 64'(ill), 64'(m_q.ill));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
    w = $urandom;
    w[6:0] = ops[$urandom_range(9, 0)];
    if (w[6:0] == 7'b0110011) begin
      case ($urandom_range(3, 0))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: w[31:25] = w[31:25];
      endcase
    end
    return w;
  endfunction

  vec_t vec [14];

  initial begin
    vec[0]  = '{32'h002081B3, 14'h2000, 4'h0, 7'h43, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{32'h0080A283, 14'h0500, 4'h2, 7'h65, 32'h00000008, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{32'hFE208EE3, 14'h1000, 4'h4, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{32'h023100B3, 14'h2001, 4'h0, 7'h41, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{32'h0020A623, 14'h0500, 4'h1, 7'h00, 32'h0000000C, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{32'hFFF00393, 14'h2400, 4'h0, 7'h47, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{32'h12345537, 14'h0400, 4'h0, 7'h4A, 32'h12345000, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{32'h80000097, 14'h0C00, 4'h8, 7'h41, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{32'h010000EF, 14'h0800, 4'h8, 7'h41, 32'h00000010, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{32'h00008067, 14'h0800, 4'hC, 7'h40, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vec[10] = '{32'h40628233, 14'h2020, 4'h0, 7'h44, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vec[11] = '{32'h0000007F, 14'h0000, 4'h0, 7'h00, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vec[12] = '{32'h042081B3, 14'h0000, 4'h0, 7'h00, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vec[13] = '{32'h002088B3, 14'h2000, 4'h0, 7'h51, 32'h00000000, 1'b0, 1'b0, 1'b1};

    m_valid = 1'b0; m_q = '0; m_pc = 32'd0;
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    ready = 1'b1; instr = 32'h00000013; pc = 32'd0;
    cycle();
    cycle();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_bundles", 64'({ctrl_ex, ctrl_mem, ctrl_wb}), 64'd0);
    chk("rst_imm_pc_ill", 64'({imm, opc, ill}), 64'd0);
    rst_n = 1'b1;

    // Decode table, one instruction per cycle
    valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      instr = vec[i].instr;
      pc    = 32'h1000 + 32'(4 * i);
      cycle();
      chk("tbl_valid", 64'(o_valid), 64'd1);
      chk("tbl_ex", 64'(ctrl_ex), 64'(vec[i].ex));
      chk("tbl_mem", 64'(ctrl_mem), 64'(vec[i].mem));
      chk("tbl_wb", 64'(ctrl_wb), 64'(vec[i].wb));
      chk("tbl_imm", 64'(imm), 64'(vec[i].imm));
      chk("tbl_ill", 64'(ill), 64'(vec[i].ill));
      chk("tbl_ill_nom", 64'(ill_n), 64'(vec[i].ill_nom));
      chk("tbl_ill_e", 64'(ill_e), 64'(vec[i].ill_e));
      chk("tbl_aux_valid", 64'({valid_n, valid_e}), 64'd3);
      if (vec[i].ill_nom) chk("nom_bundles", 64'({ex_n, mem_n, wb_n}), 64'd0);
    end

    // Load-use: lw x5 then add x6,x5,x5 while EX holds the load
    instr = 32'h0080A283; cycle();
    instr = 32'h00528333; ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1 chk("lu_ready", 64'(o_ready), 64'd0);
    chk("lu_rdreg", 64'({rd1, rd2}), 64'({5'd5, 5'd5}));
    cycle();
    chk("lu_bubble", 64'({o_valid, ctrl_ex, ctrl_mem, ctrl_wb}), 64'd0);
    ex_mem_read = 1'b0;
    #1 chk("lu_ready_after", 64'(o_ready), 64'd1);
    cycle();
    chk("lu_add", 64'({o_valid, ctrl_ex, ctrl_wb}), 64'({1'b1, 14'h2000, 7'h46}));

    // Backpressure for two cycles, then flush during a hazard
    instr = 32'h002081B3; pc = 32'h2000; cycle();
    ready = 1'b0; instr = 32'h40628233; pc = 32'h2004;
    for (int k = 0; k < 2; k++) begin
      #1 chk("bp_ready", 64'(o_ready), 64'd0);
      cycle();
      chk("bp_hold", 64'({o_valid, ctrl_ex, ctrl_wb, opc}), 64'({1'b1, 14'h2000, 7'h43, 32'h2000}));
    end
    instr = 32'h00528333; ex_mem_read = 1'b1; ex_rd = 5'd5; flush = 1'b1;
    #1 chk("fl_ready", 64'(o_ready), 64'd1);
    cycle();
    chk("fl_valid", 64'(o_valid), 64'd0);
    flush = 1'b0; ex_mem_read = 1'b0; ready = 1'b1;

    // Reset while holding a FULL register
    instr = 32'hFFF00393; pc = 32'h3000; cycle();
    ready = 1'b0; cycle();
    chk("hold_imm", 64'(imm), 64'hFFFFFFFF);
    rst_n = 1'b0; cycle();
    chk("rst2_valid", 64'({o_valid, valid_n, valid_e}), 64'd0);
    chk("rst2_bundles", 64'({ctrl_ex, ctrl_mem, ctrl_wb, ill}), 64'd0);
    chk("rst2_imm_pc", 64'({imm, opc}), 64'd0);
    rst_n = 1'b1; ready = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      instr       = rand_instr();
      pc          = $urandom;
      valid       = ($urandom_range(3, 0) != 0);
      ready       = ($urandom_range(3, 0) != 0);
      flush       = ($urandom_range(15, 0) == 0);
      ex_mem_read = 1'($urandom_range(1, 0));
      case ($urandom_range(2, 0))
        0:       ex_rd = instr[19:15];
        1:       ex_rd = instr[24:20];
        default: ex_rd = 5'($urandom_range(31, 0));
      endcase
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
